// File: rtl/l0_pool_if.sv
// Layer-0 read-out bus (rd strobe + window data) and pooled-output valid/ready stream.
interface l0_pool_if #(
  parameter int W = 18
);
  logic               rd;
  logic [3:0][W-1:0]  din_0;
  logic [3:0][W-1:0]  din_1;
  logic               pool_vld;
  logic               pool_rdy;
  logic [W-1:0]       pool_dout_0;
  logic [W-1:0]       pool_dout_1;
  logic [7:0]         pool_idx;
  logic               pool_last;

  modport master (
    output rd, din_0, din_1, pool_rdy,
    input  pool_vld, pool_dout_0, pool_dout_1, pool_idx, pool_last
  );

  modport slave (
    input  rd, din_0, din_1, pool_rdy,
    output pool_vld, pool_dout_0, pool_dout_1, pool_idx, pool_last
  );
endinterface

// File: rtl/l0_pool.sv
// Layer-0 2x2 max-pool consumer: captures non-stallable window read-outs, pools each
// channel and buffers tagged results in a FIFO drained over valid/ready.
module l0_pool #(
  parameter int W     = 18,
  parameter int DEPTH = 16,
  parameter int N_OUT = 169
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_done,
  l0_pool_if.slave     bus,
  output logic         frame_done,
  output logic         ovf
);
  localparam int         PW       = $clog2(DEPTH);
  localparam logic [7:0] LAST_IDX = 8'(N_OUT - 1);
  localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [W-1:0] m0;
    logic [W-1:0] m1;
    logic [7:0]   idx;
    logic         last;
  } entry_t;

  function automatic logic [W-1:0] max4(input logic [3:0][W-1:0] v);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = (v[0] >= v[1]) ? v[0] : v[1];
    b = (v[2] >= v[3]) ? v[2] : v[3];
    return (a >= b) ? a : b;
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic          rd_q;
  logic [7:0]    wr_idx;
  logic [7:0]    idx_cur;
  logic          is_last;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        head;

  always_ff @(posedge clk) begin
    if (rst || tx_done) rd_q <= 1'b0;
    else                rd_q <= bus.rd;
  end

  assign push  = rd_q && !tx_done && !rst;
  assign full  = (count == CNT_FULL);
  assign pop   = bus.pool_vld && bus.pool_rdy;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst || tx_done) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push && !is_last) state_nxt = ACTIVE;
      ACTIVE:  if (push && is_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A push seen in IDLE always opens a new frame at index 0.
  always_comb begin
    idx_cur = (state == IDLE) ? '0 : wr_idx;
    is_last = (idx_cur == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst || tx_done) begin
      wr_idx     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= push && is_last;
      if (push)  wr_idx <= is_last ? '0 : idx_cur + 8'd1;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {max4(bus.din_0), max4(bus.din_1), idx_cur, is_last};
  end

  // Tracks the displayed head so outputs hold the last value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst)               head_q <= '0;
    else if (bus.pool_vld) head_q <= mem[rd_ptr];
  end

  always_comb begin
    bus.pool_vld    = (count != '0);
    head            = bus.pool_vld ? mem[rd_ptr] : head_q;
    bus.pool_dout_0 = head.m0;
    bus.pool_dout_1 = head.m1;
    bus.pool_idx    = head.idx;
    bus.pool_last   = head.last;
  end
endmodule

// File: tb/tb_l0_pool.sv
// Directed bench for l0_pool: single window, full frame, back-pressure/overflow,
// full push+pop, tx_done mid-frame, extreme values and mid-stream reset.
module tb_l0_pool;
  localparam int W = 18;

  logic clk = 1'b0;
  logic rst;
  logic tx_done;
  logic frame_done;
  logic ovf;

  int checks   = 0;
  int failures = 0;
  int exp_idx  = 0;
  int nout     = 0;
  int fd_cnt   = 0;
  int last_cnt = 0;
  bit mon_en   = 1'b0;

  l0_pool_if #(.W(W)) bus ();

  l0_pool #(.W(W), .DEPTH(16), .N_OUT(169)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_done    (tx_done),
    .bus        (bus),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Window k: channel-0 max is k, channel-1 max is 2k; rd runs back-to-back.
  task automatic stream(input int k0, input int n);
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      bus.rd = (i < n);
      if (i > 0) begin
        a = W'(k0 + i - 1);
        b = W'(2 * (k0 + i - 1));
        bus.din_0 = {18'd0, a, a >> 1, 18'd0};
        bus.din_1 = {b, a, 18'd0, 18'd0};
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (frame_done) fd_cnt++;
      if (bus.pool_vld && bus.pool_rdy) begin
        chk("mon_idx",  32'(bus.pool_idx),    32'(exp_idx));
        chk("mon_d0",   32'(bus.pool_dout_0), 32'(exp_idx));
        chk("mon_d1",   32'(bus.pool_dout_1), 32'(2 * exp_idx));
        chk("mon_last", 32'(bus.pool_last),   32'(exp_idx == 168));
        if (bus.pool_last) last_cnt++;
        exp_idx++;
        nout++;
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vld"},  32'(bus.pool_vld),    32'd0);
    chk({tag, "_d0"},   32'(bus.pool_dout_0), 32'd0);
    chk({tag, "_d1"},   32'(bus.pool_dout_1), 32'd0);
    chk({tag, "_idx"},  32'(bus.pool_idx),    32'd0);
    chk({tag, "_last"}, 32'(bus.pool_last),   32'd0);
    chk({tag, "_fd"},   32'(frame_done),      32'd0);
    chk({tag, "_ovf"},  32'(ovf),             32'd0);
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tx_done = 1'b0;
    bus.rd = 1'b0;
    bus.pool_rdy = 1'b0;
    bus.din_0 = '0;
    bus.din_1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    // Single window, visible two cycles after rd
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    bus.din_0 = {18'd5, 18'd9, 18'd2, 18'd7};
    bus.din_1 = {18'd0, 18'd0, 18'd0, 18'd3};
    chk("single_vld_early", 32'(bus.pool_vld), 32'd0);
    @(negedge clk);
    chk("single_vld",  32'(bus.pool_vld),    32'd1);
    chk("single_d0",   32'(bus.pool_dout_0), 32'd9);
    chk("single_d1",   32'(bus.pool_dout_1), 32'd3);
    chk("single_idx",  32'(bus.pool_idx),    32'd0);
    chk("single_last", 32'(bus.pool_last),   32'd0);
    bus.pool_rdy = 1'b1;
    @(negedge clk);
    bus.pool_rdy = 1'b0;
    chk("single_popped", 32'(bus.pool_vld), 32'd0);
    chk("single_hold_d0", 32'(bus.pool_dout_0), 32'd9);
    pulse_tx_done();

    // Full frame streaming
    exp_idx = 0; nout = 0; fd_cnt = 0; last_cnt = 0;
    bus.pool_rdy = 1'b1;
    mon_en = 1'b1;
    stream(0, 169);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    chk("frame_nout", 32'(nout),     32'd169);
    chk("frame_fd",   32'(fd_cnt),   32'd1);
    chk("frame_last", 32'(last_cnt), 32'd1);
    chk("frame_ovf",  32'(ovf),      32'd0);

    // Back-pressure: fill 16, drop the 17th
    bus.pool_rdy = 1'b0;
    stream(0, 16);
    @(negedge clk);
    chk("bp_vld", 32'(bus.pool_vld), 32'd1);
    chk("bp_idx", 32'(bus.pool_idx), 32'd0);
    chk("bp_ovf", 32'(ovf),          32'd0);
    stream(16, 1);
    @(negedge clk);
    chk("bp_ovf_set", 32'(ovf),          32'd1);
    chk("bp_idx_hold", 32'(bus.pool_idx), 32'd0);
    exp_idx = 0; nout = 0;
    mon_en = 1'b1;
    bus.pool_rdy = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_drain_nout", 32'(nout), 32'd16);
    exp_idx = 17;
    stream(17, 1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("bp_after_nout", 32'(nout), 32'd17);

    pulse_tx_done();
    chk("txd_ovf_clr", 32'(ovf),          32'd0);
    chk("txd_vld",     32'(bus.pool_vld), 32'd0);

    // Full FIFO with simultaneous push and pop
    bus.pool_rdy = 1'b0;
    stream(0, 16);
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    bus.din_0 = {18'd0, 18'd16, 18'd8, 18'd0};
    bus.din_1 = {18'd32, 18'd16, 18'd0, 18'd0};
    bus.pool_rdy = 1'b1;
    @(negedge clk);
    bus.pool_rdy = 1'b0;
    chk("pp_ovf", 32'(ovf),          32'd0);
    chk("pp_vld", 32'(bus.pool_vld), 32'd1);
    chk("pp_idx", 32'(bus.pool_idx), 32'd1);
    exp_idx = 1; nout = 0;
    mon_en = 1'b1;
    bus.pool_rdy = 1'b1;
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    chk("pp_nout", 32'(nout), 32'd16);
    chk("pp_ovf_end", 32'(ovf), 32'd0);

    // tx_done mid-frame with 3 unread entries and a same-cycle rd
    pulse_tx_done();
    bus.pool_rdy = 1'b1;
    stream(0, 47);
    repeat (2) @(negedge clk);
    bus.pool_rdy = 1'b0;
    stream(47, 3);
    @(negedge clk);
    chk("mid_vld", 32'(bus.pool_vld), 32'd1);
    chk("mid_idx", 32'(bus.pool_idx), 32'd47);
    @(negedge clk);
    tx_done = 1'b1;
    bus.rd = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    bus.rd = 1'b0;
    chk("mid_clr_vld", 32'(bus.pool_vld), 32'd0);
    chk("mid_clr_ovf", 32'(ovf),          32'd0);
    @(negedge clk);
    chk("mid_rd_discard", 32'(bus.pool_vld), 32'd0);
    stream(5, 1);
    @(negedge clk);
    chk("mid_new_vld", 32'(bus.pool_vld),    32'd1);
    chk("mid_new_idx", 32'(bus.pool_idx),    32'd0);
    chk("mid_new_d0",  32'(bus.pool_dout_0), 32'd5);

    // Extreme values
    bus.pool_rdy = 1'b1;
    @(negedge clk);
    bus.pool_rdy = 1'b0;
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    bus.din_0 = {18'h3FFFF, 18'd0, 18'd0, 18'd0};
    bus.din_1 = {18'h155, 18'h155, 18'h155, 18'h155};
    @(negedge clk);
    chk("edge_vld", 32'(bus.pool_vld),    32'd1);
    chk("edge_d0",  32'(bus.pool_dout_0), 32'h3FFFF);
    chk("edge_d1",  32'(bus.pool_dout_1), 32'h155);
    chk("edge_idx", 32'(bus.pool_idx),    32'd1);

    // Reset mid-stream
    bus.rd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rd = 1'b0;
    chk_reset_state("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l0_pool.md
# l0_pool

Layer-0 output consumer. It accepts the 2x2 window groups that the layer-0 convolution block reads out of its two channel RAMs (rd strobe with dout_0/dout_1 four-wide buses) and max-pools each group to one value per channel. It buffers the 13x13 pooled map per channel in a small FIFO and presents it to the layer-1 stage over a valid/ready handshake. It is the receiving end of the layer-0 read-out interface, which cannot be stalled.

## Interface
- W, 18, data width of every pooled/unpooled value (post-ReLU, unsigned)
- DEPTH, 16, FIFO entries (power of two, >= 4)
- N_OUT, 169, pooled outputs per frame (13x13)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tx_done  in  1  frame abort/restart from the upstream layer; synchronous clear
- rd  in  1  layer-0 read strobe; window data valid on din_0/din_1 the following cycle
- din_0  in  4xW  channel-0 window [3:0] (layer-0 dout_0)
- din_1  in  4xW  channel-1 window [3:0] (layer-0 dout_1)
- pool_vld  out  1  FIFO head valid
- pool_rdy  in  1  downstream accepts head when pool_vld & pool_rdy
- pool_dout_0  out  W  channel-0 max of head entry
- pool_dout_1  out  W  channel-1 max of head entry
- pool_idx  out  8  frame index 0..N_OUT-1 of head entry
- pool_last  out  1  head entry is index N_OUT-1
- frame_done  out  1  one-cycle pulse when the N_OUT-th result is written into the FIFO
- ovf  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- Capture stage: rd_q <= rd (cleared by rst/tx_done). When rd_q=1, din_0/din_1 are valid this cycle.
- Max: 4-input unsigned max per channel, combinational (two compare levels). Ties: value identical, no index dependence.
- Push: on rd_q=1 the pair {max0, max1, wr_idx} is written into the FIFO at the clock edge ending that cycle. wr_idx then increments.
- wr_idx counts 0..N_OUT-1. On push with wr_idx=N_OUT-1: frame_done=1 that cycle, wr_idx wraps to 0, entry tagged last.
- Pop: pool_vld & pool_rdy advances the read pointer. pool_dout_*/pool_idx/pool_last reflect the head entry; they are undefined-but-stable (hold last) when pool_vld=0.
- Full with push and no pop: the entry is dropped, ovf<=1, and wr_idx still increments so frame indexing stays aligned.
- Full with push and pop in the same cycle: both occur; no drop.
- Empty with push: entry visible the next cycle; no combinational bypass.
- FSM states:
  - IDLE: wr_idx=0, nothing pushed this frame.
  - ACTIVE: entered on the first push; leaves to IDLE on the push of index N_OUT-1.
  - Stray rd_q in IDLE starts a new frame.
- tx_done: synchronous clear of rd_q, FIFO pointers/count, wr_idx, FSM to IDLE, ovf. A same-cycle rd or rd_q is discarded. rst takes priority over tx_done; both produce the same cleared state.
- Pointers are log2(DEPTH)-bit wrap-around; the occupancy count is log2(DEPTH)+1 bits.

## Timing
- Reset values: pool_vld=0, pool_dout_0=0, pool_dout_1=0, pool_idx=0, pool_last=0, frame_done=0, ovf=0.
- Latency: rd=1 at cycle t, din valid at t+1, entry written at the edge ending t+1, pool_vld=1 at t+2.
- Throughput: one window per cycle sustained (layer-0 may assert rd on consecutive cycles); one pop per cycle.
- Handshake: pool_vld never depends combinationally on pool_rdy. Head outputs hold while pool_vld & !pool_rdy.
- ovf and frame_done are registered. frame_done is a single-cycle pulse even if the output is back-pressured.

## Test plan
- Single window: rd pulse; next cycle din_0={5,9,2,7}, din_1={0,0,0,3} -> at t+2 pool_vld=1, pool_dout_0=9, pool_dout_1=3, pool_idx=0, pool_last=0.
- Full frame streaming: 169 windows with rd held back-to-back and pool_rdy=1; window k has ch0 max=k, ch1 max=2k -> 169 outputs in order, pool_idx=0..168, pool_last only on 168, one frame_done pulse, ovf=0.
- Back-pressure: pool_rdy=0 while 16 windows are pushed -> pool_vld=1 with the head held at idx 0. A 17th push sets ovf=1 and is dropped. After releasing pool_rdy, 16 outputs emerge (idx 0..15), and the next push carries idx 17.
- Full plus simultaneous push/pop: FIFO at 16 entries, pool_rdy=1 and rd_q=1 in the same cycle -> occupancy stays 16 and ovf stays 0.
- tx_done mid-frame: after 50 pushes with 3 unread, assert tx_done together with rd -> next cycle pool_vld=0 and ovf=0. The next window produces idx 0.
- Max edge values: din_0={2^18-1,0,0,0} and din_1 all equal 0x155 -> pool_dout_0=0x3FFFF, pool_dout_1=0x155. Reset asserted mid-stream -> all outputs return to their reset values on the next cycle.
